// File: rtl/tinyml_source_common_pkg.sv
// Shared definitions for the tinyml source-common blocks: stream-reader FSM
// state encoding and a ceiling-log2 helper for sizing pointers and counters.
package tinyml_source_common_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } reader_state_e;

    function automatic int log2_ceil(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/tinyml_source_common_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; rd_data reads as zero while empty
// so nothing stale leaks out after reset.
module tinyml_source_common_sync_fifo
    import tinyml_source_common_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [DATA_WIDTH-1:0]       wr_data,
    input  logic                        rd_en,
    output logic                        rd_valid,
    output logic [DATA_WIDTH-1:0]       rd_data,
    output logic [log2_ceil(DEPTH):0]   count
);

    localparam int PW = log2_ceil(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW:0]           wr_ptr;
    logic [PW:0]           rd_ptr;
    logic                  full;
    logic                  do_wr;
    logic                  do_rd;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count    = wr_ptr - rd_ptr;
    assign full     = count[PW];
    assign rd_valid = (count != '0);
    assign rd_data  = rd_valid ? mem[rd_ptr[PW-1:0]] : '0;
    assign do_wr    = wr_en && !full;
    assign do_rd    = rd_en && rd_valid;

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[PW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + (PW+1)'(1);
            if (do_rd) rd_ptr <= rd_ptr + (PW+1)'(1);
        end
    end

endmodule

// File: rtl/tinyml_source_common_ram_stream_reader.sv
// Streams a burst of RAM words (base_addr, length) out on a valid/ready port.
// Optional m_last output is built when TINYML_RAM_READER_LAST_EN is defined.
//
// Handshake: a beat moves on a clock edge where m_valid && m_ready; once m_valid
// rises it stays high with m_data frozen until that beat is taken.
module tinyml_source_common_ram_stream_reader
    import tinyml_source_common_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 9,
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    output logic                  ram_re,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
`ifdef TINYML_RAM_READER_LAST_EN
    output logic                  m_last,
`endif
    output reader_state_e         dbg_state
);

    localparam int CW  = ADDR_WIDTH + 1;
    localparam int FCW = log2_ceil(FIFO_DEPTH) + 1;
    localparam int OW  = FCW + 1;

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("READ_LATENCY must be 1 or 2");
    end
    if ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || FIFO_DEPTH < READ_LATENCY + 2) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2 and at least READ_LATENCY+2");
    end

    reader_state_e          state;
    logic [ADDR_WIDTH-1:0]  base_q;
    logic [CW-1:0]          len_q;
    logic [CW-1:0]          issued;
    logic [CW-1:0]          delivered;
    logic [READ_LATENCY-1:0] tag;
    logic [OW-1:0]          inflight;
    logic [FCW-1:0]         fifo_count;
    logic                   beat;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + OW'(tag[i]);
    end

    // Credit rule: every read in flight already owns a FIFO slot.
    assign ram_re    = (state == ST_READ) && (issued < len_q) &&
                       ((inflight + OW'(fifo_count)) < OW'(FIFO_DEPTH));
    assign ram_raddr = base_q + issued[ADDR_WIDTH-1:0];
    assign beat      = m_valid && m_ready;
    assign dbg_state = state;

`ifdef TINYML_RAM_READER_LAST_EN
    assign m_last = m_valid && (delivered == len_q - CW'(1));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag <= '0;
        end else begin
            tag[0] <= ram_re;
            for (int i = 1; i < READ_LATENCY; i++) tag[i] <= tag[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            base_q    <= '0;
            len_q     <= '0;
            issued    <= '0;
            delivered <= '0;
        end else begin
            done <= 1'b0;
            if (ram_re) issued <= issued + CW'(1);
            if (beat) delivered <= delivered + CW'(1);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (length != '0) begin
                            base_q    <= base_addr;
                            len_q     <= length;
                            issued    <= '0;
                            delivered <= '0;
                            busy      <= 1'b1;
                            state     <= ST_READ;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (issued == len_q) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (beat && (delivered == len_q - CW'(1))) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    tinyml_source_common_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (tag[READ_LATENCY-1]),
        .wr_data  (ram_rdata),
        .rd_en    (beat),
        .rd_valid (m_valid),
        .rd_data  (m_data),
        .count    (fifo_count)
    );

endmodule
